// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared register-file parameters and writeback requester ids.
// Imported by the writeback arbiter and its priority picker.
package rf_writeback_arbiter_pkg;

    // Register file geometry.
    localparam int RF_WORD_WIDTH  = 32;
    localparam int RF_INDEX_WIDTH = 5;

    // r0 is hard-wired to zero; writes to it are swallowed.
    localparam int RF_R0_IDX = 0;

    // Default number of writeback requesters and their slot assignment.
    localparam int RF_WB_NUM_REQ = 3;

    typedef enum logic [2:0] {
        WB_REQ_LOAD = 3'd0,
        WB_REQ_ALU  = 3'd1,
        WB_REQ_MUL  = 3'd2
    } wb_req_id_e;

endpackage

// File: rtl/rf_writeback_arbiter_wb_priority_picker.sv
// Combinational priority picker: scans valid bits starting at start_i with
// wrap-around and returns a one-hot grant plus the encoded winner id.
// Used for both rotating (start = pointer) and fixed (start = 0) priority.
module wb_priority_picker
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int NUM_REQ = RF_WB_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    start_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               any_o
);

    // First valid requester at or after start_i, wrapping past NUM_REQ-1.
    always_comb begin
        int j;
        grant_o    = '0;
        grant_id_o = '0;
        any_o      = 1'b0;
        j          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(start_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any_o && valid_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                grant_id_o = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: grants one valid/ready requester per cycle
// and drives the single register-file write port from a registered stage.
// Writes to r0 are accepted but leave rf_write_enable low.
// Build option: define RF_WB_ROUND_ROBIN_EN for rotating priority; without it
// the lowest-numbered valid requester always wins.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int NUM_REQ              = RF_WB_NUM_REQ,
    parameter int WORD_WIDTH           = RF_WORD_WIDTH,
    parameter int REGISTER_INDEX_WIDTH = RF_INDEX_WIDTH,
    localparam int ID_W                = $clog2(NUM_REQ)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ*REGISTER_INDEX_WIDTH-1:0] req_idx,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]           req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic                                    rf_write_enable,
    output logic [REGISTER_INDEX_WIDTH-1:0]         rf_write_idx,
    output logic [WORD_WIDTH-1:0]                   rf_write_data,
    output logic [ID_W-1:0]                         grant_id
);

    logic [ID_W-1:0]                 start_ptr;
    logic [NUM_REQ-1:0]              pick_grant;
    logic [ID_W-1:0]                 pick_id;
    logic                            pick_any;
    logic                            transfer;
    logic [REGISTER_INDEX_WIDTH-1:0] sel_idx;
    logic [WORD_WIDTH-1:0]           sel_data;

    logic                            wen_q,  wen_d;
    logic [REGISTER_INDEX_WIDTH-1:0] widx_q, widx_d;
    logic [WORD_WIDTH-1:0]           wdata_q, wdata_d;
    logic [ID_W-1:0]                 gid_q,  gid_d;

`ifdef RF_WB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Rotate priority to just past the last winner; hold when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start_ptr = ptr_q;
`else
    assign start_ptr = '0;
`endif

    wb_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .valid_i    (req_valid),
        .start_i    (start_ptr),
        .grant_o    (pick_grant),
        .grant_id_o (pick_id),
        .any_o      (pick_any)
    );

    // Readiness is suppressed during reset so no offer is consumed then.
    assign req_ready = reset ? '0 : pick_grant;
    assign transfer  = pick_any && !reset;

    assign sel_idx  = req_idx[int'(pick_id)*REGISTER_INDEX_WIDTH +: REGISTER_INDEX_WIDTH];
    assign sel_data = req_data[int'(pick_id)*WORD_WIDTH +: WORD_WIDTH];

    // Next write-port contents: load the winner, otherwise idle and hold.
    always_comb begin
        wen_d   = 1'b0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        if (transfer) begin
            wen_d   = (sel_idx != REGISTER_INDEX_WIDTH'(RF_R0_IDX));
            widx_d  = sel_idx;
            wdata_d = sel_data;
            gid_d   = pick_id;
        end
    end

    // Registered write-port stage; reset drops any write already staged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wen_q   <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
        end else begin
            wen_q   <= wen_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end

    assign rf_write_enable = wen_q;
    assign rf_write_idx    = widx_q;
    assign rf_write_data   = wdata_q;
    assign grant_id        = gid_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter (3 requesters, 32-bit data).
// A reference model predicts each grant and the next write-port contents;
// predictions are queued before the clock edge and compared after it.
module tb_rf_writeback_arbiter;

    localparam int N    = 3;
    localparam int W    = 32;
    localparam int RIW  = 5;
    localparam int IDW  = 2;

    logic               clk;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N*RIW-1:0]   req_idx;
    logic [N*W-1:0]     req_data;
    logic [N-1:0]       req_ready;
    logic               rf_write_enable;
    logic [RIW-1:0]     rf_write_idx;
    logic [W-1:0]       rf_write_data;
    logic [IDW-1:0]     grant_id;

    logic [RIW-1:0]     idx_a  [N];
    logic [W-1:0]       data_a [N];
    logic [W-1:0]       rf_mem [32];

    typedef struct packed {
        logic           en;
        logic [RIW-1:0] idx;
        logic [W-1:0]   data;
        logic [IDW-1:0] gid;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_m;
    int   ptr_m;
    int   n_tests;
    int   n_fail;

    rf_writeback_arbiter #(
        .NUM_REQ              (N),
        .WORD_WIDTH           (W),
        .REGISTER_INDEX_WIDTH (RIW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_idx         (req_idx),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rf_write_enable (rf_write_enable),
        .rf_write_idx    (rf_write_idx),
        .rf_write_data   (rf_write_data),
        .grant_id        (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_idx  = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_idx[i*RIW +: RIW] = idx_a[i];
            req_data[i*W +: W]    = data_a[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic offer(input int i, input logic [RIW-1:0] idx, input logic [W-1:0] data);
        req_valid[i] = 1'b1;
        idx_a[i]     = idx;
        data_a[i]    = data;
    endtask

    // One clock: predict before the edge, check the registered port after it.
    task automatic cycle();
        int             g;
        exp_t           e;
        exp_t           got;
        logic [N-1:0]   er;
        logic           wen;
        logic [RIW-1:0] widx;
        logic [W-1:0]   wdat;
        @(negedge clk);
        wen  = rf_write_enable;
        widx = rf_write_idx;
        wdat = rf_write_data;
        g    = -1;
        er   = '0;
`ifdef RF_WB_ROUND_ROBIN_EN
        if (!reset) g = pick(req_valid, ptr_m);
`else
        if (!reset) g = pick(req_valid, 0);
`endif
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        if (reset) begin
            e     = '0;
            ptr_m = 0;
        end else if (g >= 0) begin
            e.en   = (idx_a[g] != '0);
            e.idx  = idx_a[g];
            e.data = data_a[g];
            e.gid  = g[IDW-1:0];
            ptr_m  = (g + 1) % N;
        end else begin
            e    = last_m;
            e.en = 1'b0;
        end
        last_m = e;
        exp_q.push_back(e);
        @(posedge clk);
        if (wen) rf_mem[widx] = wdat;
        #1;
        if (g >= 0) req_valid[g] = 1'b0;
        got = exp_q.pop_front();
        check("rf_write_enable", 64'(rf_write_enable), 64'(got.en));
        check("rf_write_idx",    64'(rf_write_idx),    64'(got.idx));
        check("rf_write_data",   64'(rf_write_data),   64'(got.data));
        check("grant_id",        64'(grant_id),        64'(got.gid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDW-1:0] order [6];
        n_tests   = 0;
        n_fail    = 0;
        ptr_m     = 0;
        last_m    = '0;
        reset     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            idx_a[i]  = '0;
            data_a[i] = '0;
        end
        for (int r = 0; r < 32; r++) rf_mem[r] = '0;

        // Reset, then idle.
        cycle();
        cycle();
        reset = 1'b0;
        repeat (5) cycle();

        // Single write from requester 0.
        offer(0, 5'd7, 32'hDEADBEEF);
        cycle();
        check("single_en",  64'(rf_write_enable), 64'd1);
        check("single_gid", 64'(grant_id),        64'd0);
        cycle();
        check("single_r7",  64'(rf_mem[7]),       64'hDEADBEEF);

        // Contention from pointer 0: all three valid for six cycles.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
`ifdef RF_WB_ROUND_ROBIN_EN
            order[k] = IDW'(k % N);
`else
            order[k] = '0;
`endif
        end
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) offer(i, RIW'(i + 1), W'(32'h100 + i));
            cycle();
            check("contention_order", 64'(grant_id), 64'(order[k]));
        end
        req_valid = '0;
        cycle();

        // Write to r0 is granted but suppressed.
        offer(1, 5'd0, 32'h12345678);
        cycle();
        check("r0_gid", 64'(grant_id),        64'd1);
        check("r0_en",  64'(rf_write_enable), 64'd0);
        cycle();
        check("r0_mem", 64'(rf_mem[0]),       64'd0);

        // Same-index collision from pointer 0.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        offer(0, 5'd5, 32'hA);
        offer(2, 5'd5, 32'hB);
        cycle();
        check("collide_first_gid",  64'(grant_id),      64'd0);
        check("collide_first_dat",  64'(rf_write_data), 64'hA);
        cycle();
        check("collide_second_gid", 64'(grant_id),      64'd2);
        check("collide_second_dat", 64'(rf_write_data), 64'hB);
        cycle();
        check("collide_r5",         64'(rf_mem[5]),     64'hB);

        // Offer pending during reset is not taken; granted right after.
        offer(1, 5'd9, 32'hCAFE0009);
        reset = 1'b1;
        cycle();
        check("midreset_en", 64'(rf_write_enable), 64'd0);
        reset = 1'b0;
        cycle();
        check("postreset_gid", 64'(grant_id),     64'd1);
        check("postreset_idx", 64'(rf_write_idx), 64'd9);
        cycle();
        check("postreset_r9",  64'(rf_mem[9]),    64'hCAFE0009);

        // Sustained random traffic checked against the model every cycle.
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    offer(i, RIW'($urandom_range(0, 31)), W'($urandom));
                end
            end
            cycle();
        end
        req_valid = '0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
